// File: rtl/sha256_msg_sched.sv
// Streaming SHA-256 message-schedule generator: loads 16 words, emits W[0..63].
// Optional feature: define SHA256_SCHED_BLKCNT_EN to add the completed-block counter output blk_cnt.
//
// state | meaning
// LOAD  | accepting M[0..15] into the window
// EMIT  | presenting W[t] = win[0]; each handshake shifts in W[t+16]
module sha256_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [WORD_W-1:0] blk_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [5:0]        w_idx,
  output logic              w_last,
  output logic              busy
`ifdef SHA256_SCHED_BLKCNT_EN
  ,output logic [15:0]      blk_cnt
`endif
);

  typedef enum logic {ST_LOAD, ST_EMIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [3:0]        load_cnt_q, load_cnt_d;
  logic [5:0]        idx_q, idx_d;
  logic [WORD_W-1:0] win_q [16];

  logic              in_hs, out_hs, shift_en;
  logic [WORD_W-1:0] shift_in, w_next;
  logic [WORD_W-1:0] op_a, op_b, op_c, op_d;
  logic [WORD_W-1:0] s1, c1, s2, c2;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign blk_ready = (state_q == ST_LOAD);
  assign w_valid   = (state_q == ST_EMIT);
  assign w_word    = w_valid ? win_q[0] : '0;
  assign w_idx     = idx_q;
  assign w_last    = w_valid && (idx_q == LAST_IDX);
  assign busy      = (state_q == ST_EMIT) || (load_cnt_q != 4'd0);

  assign in_hs    = blk_valid && blk_ready;
  assign out_hs   = w_valid && w_ready;
  assign shift_en = !flush && (in_hs || out_hs);

  // Two carry-save levels reduce the four operands before one carry-propagate add.
  always_comb begin
    op_a   = sig1(win_q[14]);
    op_b   = win_q[9];
    op_c   = sig0(win_q[1]);
    op_d   = win_q[0];
    s1     = op_a ^ op_b ^ op_c;
    c1     = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;
    s2     = s1 ^ c1 ^ op_d;
    c2     = ((s1 & c1) | (s1 & op_d) | (c1 & op_d)) << 1;
    w_next = s2 + c2;
  end

  assign shift_in = (state_q == ST_LOAD) ? blk_word : w_next;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    if (flush) begin
      state_d    = ST_LOAD;
      load_cnt_d = 4'd0;
      idx_d      = 6'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            if (load_cnt_q == 4'd15) begin
              state_d    = ST_EMIT;
              load_cnt_d = 4'd0;
              idx_d      = 6'd0;
            end else begin
              load_cnt_d = load_cnt_q + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (out_hs) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_LOAD;
              idx_d   = 6'd0;
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= 4'd0;
      idx_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Words shifted in past W[63] are never presented; the next load overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= shift_in;
    end
  end

`ifdef SHA256_SCHED_BLKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= 16'd0;
    end else if (!flush && out_hs && (idx_q == LAST_IDX)) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: abc/zero blocks, stall, flush, back-to-back, reset.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;
`ifdef SHA256_SCHED_BLKCNT_EN
  logic [15:0] blk_cnt;
  int          exp_blk;
`endif

  int n_vec;
  int n_mis;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_word    (w_word),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
`ifdef SHA256_SCHED_BLKCNT_EN
    ,.blk_cnt  (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input logic [31:0] m [16], output logic [31:0] w [64]);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_w_word"}, w_word, 32'd0);
    chk({tag, "_w_idx"}, 32'(w_idx), 32'd0);
    chk({tag, "_w_last"}, 32'(w_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
  endtask

  // Drives the first n words; ends at a negedge with blk_valid low.
  task automatic send_words(input logic [31:0] m [16], input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!blk_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("load_ready", 32'(blk_ready), 32'd1);
      blk_valid = 1'b1;
      blk_word  = m[i];
      @(negedge clk);
    end
    blk_valid = 1'b0;
  endtask

  task automatic run_sched(input logic [31:0] exp [64], input int stall_at, input int stall_len,
                           input int flush_at, output logic [31:0] got [64]);
    int guard;
    for (int t = 0; t < 64; t++) got[t] = 32'd0;
    for (int t = 0; t < 64; t++) begin
      guard = 0;
      while (!w_valid && guard < 200) begin
        w_ready = 1'b0;
        @(negedge clk);
        guard++;
      end
      if (t == stall_at) begin
        w_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(w_valid), 32'd1);
          chk("stall_idx", 32'(w_idx), 32'(t));
          chk("stall_word", w_word, exp[t]);
        end
      end
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_idx", 32'(w_idx), 32'(t));
      chk("w_word", w_word, exp[t]);
      chk("w_last", 32'(w_last), (t == 63) ? 32'd1 : 32'd0);
      got[t] = w_word;
      w_ready = 1'b1;
      if (t == flush_at) begin
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        w_ready = 1'b0;
        chk("flush_w_valid", 32'(w_valid), 32'd0);
        chk("flush_blk_ready", 32'(blk_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
    w_ready = 1'b0;
    chk("end_w_valid", 32'(w_valid), 32'd0);
    chk("end_blk_ready", 32'(blk_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
`ifdef SHA256_SCHED_BLKCNT_EN
    exp_blk++;
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    check_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SHA256_SCHED_BLKCNT_EN
    exp_blk = 0;
`endif
  endtask

  logic [31:0] m_abc [16];
  logic [31:0] m_zero [16];
  logic [31:0] m_seq [16];
  logic [31:0] e_abc [64];
  logic [31:0] e_zero [64];
  logic [31:0] e_seq [64];
  logic [31:0] got [64];

  initial begin
    n_vec     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    blk_valid = 1'b0;
    blk_word  = 32'd0;
    w_ready   = 1'b0;
`ifdef SHA256_SCHED_BLKCNT_EN
    exp_blk = 0;
`endif
    for (int i = 0; i < 16; i++) begin
      m_abc[i]  = 32'd0;
      m_zero[i] = 32'd0;
      m_seq[i]  = 32'h0101_0101 * (i + 1) ^ 32'hA5A5_0000;
    end
    m_abc[0]  = 32'h6162_6380;
    m_abc[15] = 32'h0000_0018;
    model(m_abc, e_abc);
    model(m_zero, e_zero);
    model(m_seq, e_seq);

    repeat (2) @(negedge clk);
    check_idle("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // abc block, consumer always ready
    send_words(m_abc, 16);
    run_sched(e_abc, -1, 0, -1, got);
    chk("abc_w0", got[0], 32'h6162_6380);
    chk("abc_w15", got[15], 32'h0000_0018);
    chk("abc_w16", got[16], 32'h6162_6380);
    chk("abc_w17", got[17], 32'h000F_0000);
    chk("abc_w18", got[18], 32'h7DA8_6405);

    // all-zero block
    send_words(m_zero, 16);
    run_sched(e_zero, -1, 0, -1, got);

    // backpressure at t = 20
    send_words(m_abc, 16);
    run_sched(e_abc, 20, 5, -1, got);

    // flush at t = 30 with w_ready high, then a partial load flushed in LOAD
    send_words(m_seq, 16);
    run_sched(e_seq, -1, 0, 30, got);
    send_words(m_seq, 5);
    chk("partial_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("partial_flush_busy", 32'(busy), 32'd0);
`ifdef SHA256_SCHED_BLKCNT_EN
    chk("blk_cnt_after_flush", 32'(blk_cnt), 32'(exp_blk));
`endif
    send_words(m_abc, 16);
    run_sched(e_abc, -1, 0, -1, got);
    chk("reflush_w16", got[16], 32'h6162_6380);

    // back-to-back blocks with blk_valid held high during emission
    apply_reset();
    send_words(m_abc, 16);
    blk_valid = 1'b1;
    blk_word  = 32'hDEAD_BEEF;
    run_sched(e_abc, -1, 0, -1, got);
    send_words(m_seq, 16);
    run_sched(e_seq, -1, 0, -1, got);
`ifdef SHA256_SCHED_BLKCNT_EN
    chk("blk_cnt_b2b", 32'(blk_cnt), 32'd2);
`endif

    // reset mid-load after 8 words
    send_words(m_seq, 8);
    chk("mid_load_busy", 32'(busy), 32'd1);
    #2;
    apply_reset();
    check_idle("post_mid_rst");
    send_words(m_abc, 16);
    run_sched(e_abc, -1, 0, -1, got);
    chk("after_rst_w0", got[0], 32'h6162_6380);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Streaming SHA-256 message-schedule generator.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input.
- Expands the block into the 64-word schedule W[0..63].
- Emits W[t] one word per handshake over a valid/ready output to the round datapath.
- Each expanded word is the 4-operand modular sum that the codebase's 4:2 compressor reduces. This block is the producer/feeder side of that adder.

Parameters:
- WORD_W, 32, word width; only 32 is supported.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards the current block.
- blk_valid  input  1  input word valid.
- blk_ready  output  1  block ready to accept an input word.
- blk_word  input  32  message word M[i], i = 0..15 in order.
- w_valid  output  1  schedule word valid.
- w_ready  input  1  consumer ready.
- w_word  output  32  schedule word W[t].
- w_idx  output  6  t of the presented word.
- w_last  output  1  high when w_idx == 63 and w_valid == 1.
- busy  output  1  high in EMIT, or in LOAD with load count != 0.

Behaviour:
- State machine: LOAD and EMIT. Reset state is LOAD, with load count 0 and emit count 0.
- Reset values: w_valid 0, w_word 0, w_idx 0, w_last 0, busy 0, all window registers 0.
- blk_ready is 1 whenever state is LOAD. Handshakes while rst_n is low have no effect.
- LOAD:
  - Each blk_valid & blk_ready handshake shifts blk_word into window entry 15. The window shifts down; entry 0 holds the oldest word.
  - The load count increments on each handshake.
  - On the 16th handshake, move to EMIT. The next cycle w_valid = 1, w_word = M[0], w_idx = 0.
- EMIT:
  - w_word = win[0]. blk_ready = 0.
  - On a w_valid & w_ready handshake, the window shifts down and win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - w_idx increments on each handshake.
- Backpressure: while w_valid = 1 and w_ready = 0, w_word, w_idx and w_last are held stable. No shift occurs.
- End of block:
  - The handshake at w_idx = 63 returns the block to LOAD.
  - The next cycle: w_valid = 0, blk_ready = 1, counts = 0.
  - No bubble beyond that one cycle. Words computed past W[63] are discarded.
- flush:
  - When asserted, the next state is LOAD with counts cleared and w_valid = 0. Window contents are don't-care.
  - flush has priority over a simultaneous input or output handshake; that handshake is dropped.
  - flush in LOAD discards any partially loaded words.
- Latency: the 16th input handshake at cycle N gives W[0] valid at cycle N+1. With w_ready held high, W[t] appears at cycle N+1+t.
- Asynchronous reset mid-block returns all outputs and state to reset values immediately.

Optional Feature:
- Macro: SHA256_SCHED_BLKCNT_EN.
- When defined:
  - Adds output blk_cnt, 16 bits, reset 0.
  - blk_cnt increments on each w_idx = 63 handshake and wraps 0xFFFF -> 0x0000.
  - blk_cnt is not cleared by flush, and a flushed block is not counted.
- When undefined: the port is absent and there is no counter logic.

Test Plan:
- "abc" padded block (M[0] = 0x61626380, M[1..14] = 0, M[15] = 0x00000018), w_ready = 1: W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000, W[18] = 0x7DA86405. All 64 words match the software model; w_last is high only at t = 63.
- All-zero block: all 64 w_word = 0x00000000, w_idx counts 0..63, then blk_ready = 1 the next cycle.
- Backpressure: w_ready = 0 for 5 cycles while w_idx = 20. w_word and w_idx stay stable, no index is skipped or duplicated, and the word sequence matches the unstalled run.
- flush asserted while w_idx = 30, same cycle as w_ready = 1: next cycle w_valid = 0 and blk_ready = 1. The following "abc" block yields W[16] = 0x61626380 again.
- Back-to-back blocks with blk_valid held high: blk_ready rises 1 cycle after the t = 63 handshake. With the macro defined, blk_cnt reads 2 after the second block.
- rst_n pulsed low after 8 input words: outputs return to reset values. A full 16-word block then loads and produces the correct schedule from W[0].
